// File: rtl/mdu_pipe.sv
// mdu_pipe: RV32M execution unit. Pipelined multiplier plus iterative
// restoring divider sharing one issue port and one registered result slot.
// Optional feature macro: MDU_DIV_EARLY_OUT_EN (divide-by-zero and signed
// overflow skip the CALC/FIX sequence and go straight to DONE).
module mdu_pipe #(
    parameter int DATA_W     = 32,
    parameter int ROB_W      = 4,
    parameter int MUL_STAGES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rs2mdu_enable,
    input  logic [2:0]        rs2mdu_op,
    input  logic [DATA_W-1:0] rs2mdu_rs1,
    input  logic [DATA_W-1:0] rs2mdu_rs2,
    input  logic [ROB_W-1:0]  rs2mdu_reorder,
    output logic              mdu2rs_ready,
    input  logic              rob2mdu_flush,
    output logic              mdu2cdb_enable,
    output logic [ROB_W-1:0]  mdu2cdb_reorder,
    output logic [DATA_W-1:0] mdu2cdb_value
);

    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} div_state_e;

    div_state_e div_state_q, div_state_d;

    logic kill, issue_ok, mul_issue, div_issue;

    assign kill         = rst || rob2mdu_flush;
    assign mdu2rs_ready = (div_state_q == S_IDLE);
    assign issue_ok     = rs2mdu_enable && mdu2rs_ready && !rst && !rob2mdu_flush;
    assign mul_issue    = issue_ok && !rs2mdu_op[2];
    assign div_issue    = issue_ok && rs2mdu_op[2];

    // ---------------- multiplier ----------------
    logic                 a_sgn, b_sgn;
    logic [2*DATA_W-1:0]  a_ext, b_ext, prod;
    logic [DATA_W-1:0]    mul_res;

    logic [MUL_STAGES-1:0] mul_vld_q;
    logic [ROB_W-1:0]      mul_tag_q [MUL_STAGES];
    logic [DATA_W-1:0]     mul_res_q [MUL_STAGES];
    logic                  mul_last;

    // Extend operands per op and select the product half at issue time.
    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        case (rs2mdu_op[1:0])
            2'b00, 2'b01: begin
                a_sgn = rs2mdu_rs1[DATA_W-1];
                b_sgn = rs2mdu_rs2[DATA_W-1];
            end
            2'b10:   a_sgn = rs2mdu_rs1[DATA_W-1];
            default: ;
        endcase
        a_ext   = {{DATA_W{a_sgn}}, rs2mdu_rs1};
        b_ext   = {{DATA_W{b_sgn}}, rs2mdu_rs2};
        prod    = a_ext * b_ext;
        mul_res = (rs2mdu_op[1:0] == 2'b00) ? prod[DATA_W-1:0] : prod[2*DATA_W-1:DATA_W];
    end

    // Valid bits of the multiplier pipe; flush/reset empties it.
    always_ff @(posedge clk) begin
        if (kill) begin
            mul_vld_q <= '0;
        end else begin
            mul_vld_q[0] <= mul_issue;
            for (int unsigned i = 1; i < MUL_STAGES; i++) begin
                mul_vld_q[i] <= mul_vld_q[i-1];
            end
        end
    end

    // Tag and result payload travel alongside the valid bits.
    always_ff @(posedge clk) begin
        mul_tag_q[0] <= rs2mdu_reorder;
        mul_res_q[0] <= mul_res;
        for (int unsigned i = 1; i < MUL_STAGES; i++) begin
            mul_tag_q[i] <= mul_tag_q[i-1];
            mul_res_q[i] <= mul_res_q[i-1];
        end
    end

    assign mul_last = mul_vld_q[MUL_STAGES-1];

    // ---------------- divider ----------------
    logic              a_neg, b_neg, div_by_zero, div_ovf, div_special;
    logic [DATA_W-1:0] a_mag, b_mag, spec_res, quot_fix, rem_fix;
    logic [DATA_W:0]   rem_sh, diff;

    logic [ROB_W-1:0]  div_tag_q;
    logic              rem_sel_q, q_neg_q, r_neg_q, special_q;
    logic [DATA_W-1:0] rem_q, quot_q, dvsr_q, result_q;
    logic [CNT_W-1:0]  cnt_q;

    // Issue-time magnitudes and the architecturally defined special results.
    always_comb begin
        a_neg       = !rs2mdu_op[0] && rs2mdu_rs1[DATA_W-1];
        b_neg       = !rs2mdu_op[0] && rs2mdu_rs2[DATA_W-1];
        a_mag       = a_neg ? -rs2mdu_rs1 : rs2mdu_rs1;
        b_mag       = b_neg ? -rs2mdu_rs2 : rs2mdu_rs2;
        div_by_zero = (rs2mdu_rs2 == '0);
        div_ovf     = !rs2mdu_op[0] && (rs2mdu_rs1 == MIN_NEG) && (rs2mdu_rs2 == '1);
        div_special = div_by_zero || div_ovf;
        spec_res    = '0;
        if (div_by_zero) begin
            spec_res = rs2mdu_op[1] ? rs2mdu_rs1 : '1;
        end else if (div_ovf) begin
            spec_res = rs2mdu_op[1] ? '0 : rs2mdu_rs1;
        end
        rem_sh   = {rem_q, quot_q[DATA_W-1]};
        diff     = rem_sh - {1'b0, dvsr_q};
        quot_fix = q_neg_q ? -quot_q : quot_q;
        rem_fix  = r_neg_q ? -rem_q : rem_q;
    end

    // Divider state register; flush/reset return it to IDLE.
    always_ff @(posedge clk) begin
        if (kill) div_state_q <= S_IDLE;
        else      div_state_q <= div_state_d;
    end

    // Divider sequencing; DONE waits for a cycle with no multiplier result.
    always_comb begin
        div_state_d = div_state_q;
        case (div_state_q)
            S_IDLE: begin
                if (div_issue) begin
`ifdef MDU_DIV_EARLY_OUT_EN
                    div_state_d = div_special ? S_DONE : S_CALC;
`else
                    div_state_d = S_CALC;
`endif
                end
            end
            S_CALC:  if (cnt_q == '0) div_state_d = S_FIX;
            S_FIX:   div_state_d = S_DONE;
            S_DONE:  if (!mul_last) div_state_d = S_IDLE;
            default: div_state_d = S_IDLE;
        endcase
    end

    // Divider datapath: the special result is latched at issue and FIX
    // leaves it untouched, so both build variants return identical values.
    always_ff @(posedge clk) begin
        case (div_state_q)
            S_IDLE: begin
                if (div_issue) begin
                    div_tag_q <= rs2mdu_reorder;
                    rem_sel_q <= rs2mdu_op[1];
                    q_neg_q   <= a_neg ^ b_neg;
                    r_neg_q   <= a_neg;
                    special_q <= div_special;
                    rem_q     <= '0;
                    quot_q    <= a_mag;
                    dvsr_q    <= b_mag;
                    cnt_q     <= CNT_W'(DATA_W-1);
                    result_q  <= spec_res;
                end
            end
            S_CALC: begin
                quot_q <= {quot_q[DATA_W-2:0], !diff[DATA_W]};
                rem_q  <= diff[DATA_W] ? rem_sh[DATA_W-1:0] : diff[DATA_W-1:0];
                cnt_q  <= cnt_q - CNT_W'(1);
            end
            S_FIX: begin
                if (!special_q) result_q <= rem_sel_q ? rem_fix : quot_fix;
            end
            default: ;
        endcase
    end

    // Result broadcast register: multiplier has priority over a waiting divide.
    always_ff @(posedge clk) begin
        if (rst) begin
            mdu2cdb_enable  <= 1'b0;
            mdu2cdb_reorder <= '0;
            mdu2cdb_value   <= '0;
        end else if (rob2mdu_flush) begin
            mdu2cdb_enable  <= 1'b0;
        end else if (mul_last) begin
            mdu2cdb_enable  <= 1'b1;
            mdu2cdb_reorder <= mul_tag_q[MUL_STAGES-1];
            mdu2cdb_value   <= mul_res_q[MUL_STAGES-1];
        end else if (div_state_q == S_DONE) begin
            mdu2cdb_enable  <= 1'b1;
            mdu2cdb_reorder <= div_tag_q;
            mdu2cdb_value   <= result_q;
        end else begin
            mdu2cdb_enable  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mdu_pipe.sv
// Testbench for mdu_pipe: table vectors, directed multi-cycle sequences and
// randomized traffic checked against an arithmetic reference model.
module tb_mdu_pipe;

`ifdef MDU_DIV_EARLY_OUT_EN
    localparam int SPEC_LAT = 1;
`else
    localparam int SPEC_LAT = 34;
`endif
    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 34;

    logic        clk = 1'b0;
    logic        rst, en, flush;
    logic [2:0]  op;
    logic [31:0] rs1, rs2;
    logic [3:0]  tag;
    logic        ready, cdb_en;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_val;

    mdu_pipe #(.DATA_W(32), .ROB_W(4), .MUL_STAGES(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .rs2mdu_enable   (en),
        .rs2mdu_op       (op),
        .rs2mdu_rs1      (rs1),
        .rs2mdu_rs2      (rs2),
        .rs2mdu_reorder  (tag),
        .mdu2rs_ready    (ready),
        .rob2mdu_flush   (flush),
        .mdu2cdb_enable  (cdb_en),
        .mdu2cdb_reorder (cdb_tag),
        .mdu2cdb_value   (cdb_val)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int npulse = 0;
    logic        exp_pend [16];
    logic [31:0] exp_val  [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: RISC-V M semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (o)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int pending_count();
        int c = 0;
        for (int i = 0; i < 16; i++) if (exp_pend[i]) c++;
        return c;
    endfunction

    function automatic void clear_pending();
        for (int i = 0; i < 16; i++) exp_pend[i] = 1'b0;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard: every broadcast must match an outstanding tag and its value.
    always @(negedge clk) begin
        if (cdb_en === 1'b1) begin
            npulse++;
            total++;
            if (!exp_pend[cdb_tag]) begin
                bad++;
                $display("FAIL sb_unexpected: tag=%0d value=%0h required=no pulse", cdb_tag, cdb_val);
            end else begin
                if (cdb_val !== exp_val[cdb_tag]) begin
                    bad++;
                    $display("FAIL sb_value tag %0d: actual=%0h required=%0h", cdb_tag, cdb_val, exp_val[cdb_tag]);
                end
                exp_pend[cdb_tag] = 1'b0;
            end
        end
    end

    // Called #1 after an edge; the op is presented to the following edge.
    task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] t, input logic fl);
        if (ready && !fl) begin
            exp_pend[t] = 1'b1;
            exp_val[t]  = model(o, a, b);
        end
        en = 1'b1; op = o; rs1 = a; rs2 = b; tag = t; flush = fl;
        @(posedge clk); #1;
        en = 1'b0; flush = 1'b0;
        if (fl) clear_pending();
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        clear_pending();
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        logic [31:0] val;
        int          lat;
    } vec_t;

    localparam int NV = 17;
    vec_t vt [NV];

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   k, p0, c0;
        bit   seen;
        int   rdy_bad;
        int   gt[$];
        int   gc[$];
        logic [3:0] rt;

        vt[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 4'd5,  32'hFFFF_FFEB, MUL_LAT};
        vt[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 4'd1,  32'h4000_0000, MUL_LAT};
        vt[2]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 4'd2,  32'hFFFF_FFFF, MUL_LAT};
        vt[3]  = '{3'd3, 32'hFFFF_FFFF,  32'd2,         4'd3,  32'h0000_0001, MUL_LAT};
        vt[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         4'd6,  32'hFFFF_FFFD, DIV_LAT};
        vt[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         4'd7,  32'hFFFF_FFFF, DIV_LAT};
        vt[6]  = '{3'd5, 32'hFFFF_FFF9,  32'd2,         4'd8,  32'h7FFF_FFFC, DIV_LAT};
        vt[7]  = '{3'd7, 32'hFFFF_FFF9,  32'd2,         4'd9,  32'h0000_0001, DIV_LAT};
        vt[8]  = '{3'd4, 32'h0000_1234,  32'd0,         4'd10, 32'hFFFF_FFFF, SPEC_LAT};
        vt[9]  = '{3'd6, 32'h0000_1234,  32'd0,         4'd11, 32'h0000_1234, SPEC_LAT};
        vt[10] = '{3'd5, 32'hF000_1234,  32'd0,         4'd12, 32'hFFFF_FFFF, SPEC_LAT};
        vt[11] = '{3'd7, 32'hF000_1234,  32'd0,         4'd13, 32'hF000_1234, SPEC_LAT};
        vt[12] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 4'd14, 32'h8000_0000, SPEC_LAT};
        vt[13] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 4'd15, 32'h0000_0000, SPEC_LAT};
        vt[14] = '{3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 4'd0,  32'h0000_0000, DIV_LAT};
        vt[15] = '{3'd4, 32'd7,          32'hFFFF_FFFE, 4'd4,  32'hFFFF_FFFD, DIV_LAT};
        vt[16] = '{3'd6, 32'd7,          32'hFFFF_FFFE, 4'd5,  32'h0000_0001, DIV_LAT};

        clear_pending();
        rst = 1'b1; en = 1'b0; flush = 1'b0; op = '0; rs1 = '0; rs2 = '0; tag = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_enable",  32'(cdb_en),  32'd0);
        check("rst_reorder", 32'(cdb_tag), 32'd0);
        check("rst_value",   cdb_val,      32'd0);
        rst = 1'b0;
        check("rst_ready",   32'(ready),   32'd1);
        idle(1);

        // Table vectors, one op at a time, with latency and ready checks.
        for (int i = 0; i < NV; i++) begin
            drive(vt[i].op, vt[i].a, vt[i].b, vt[i].tag, 1'b0);
            k = 0; seen = 0; rdy_bad = 0;
            while (!seen && k < 100) begin
                if (cdb_en === 1'b1) begin
                    seen = 1;
                end else begin
                    if (vt[i].op[2] && ready) rdy_bad++;
                    @(posedge clk); #1;
                    k++;
                end
            end
            check($sformatf("v%0d_seen", i),       32'(seen),    32'd1);
            check($sformatf("v%0d_latency", i),    k,            vt[i].lat);
            check($sformatf("v%0d_tag", i),        32'(cdb_tag), 32'(vt[i].tag));
            check($sformatf("v%0d_value", i),      cdb_val,      vt[i].val);
            check($sformatf("v%0d_ready_low", i),  rdy_bad,      32'd0);
            check($sformatf("v%0d_ready_back", i), 32'(ready),   32'd1);
            idle(1);
            check($sformatf("v%0d_one_pulse", i),  32'(cdb_en),  32'd0);
        end

        // Back-to-back multiplies: consecutive pulses, tags in order.
        c0 = cyc + 1;
        drive(3'd1, 32'h8000_0000, 32'h8000_0000, 4'd1, 1'b0);
        drive(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2, 1'b0);
        drive(3'd3, 32'hFFFF_FFFF, 32'd2,         4'd3, 1'b0);
        gt.delete(); gc.delete();
        for (int j = 0; j < 20; j++) begin
            if (cdb_en === 1'b1) begin gt.push_back(int'(cdb_tag)); gc.push_back(cyc); end
            @(posedge clk); #1;
        end
        check("b2b_count", gt.size(), 32'd3);
        for (int j = 0; j < 3; j++) begin
            if (j < gt.size()) begin
                check($sformatf("b2b%0d_tag", j),   gt[j], j + 1);
                check($sformatf("b2b%0d_cycle", j), gc[j] - c0, MUL_LAT + j);
            end
        end

        // Multiply result collides with a special-case divide.
        c0 = cyc + 1;
        drive(3'd0, 32'd3, 32'd5, 4'd1, 1'b0);
        idle(1);
        drive(3'd4, 32'h55, 32'd0, 4'd2, 1'b0);
        gt.delete(); gc.delete();
        for (int j = 0; j < 45; j++) begin
            if (cdb_en === 1'b1) begin gt.push_back(int'(cdb_tag)); gc.push_back(cyc); end
            @(posedge clk); #1;
        end
        check("coll_count", gt.size(), 32'd2);
        if (gt.size() == 2) begin
            check("coll_mul_tag",   gt[0], 32'd1);
            check("coll_mul_cycle", gc[0] - c0, MUL_LAT);
            check("coll_div_tag",   gt[1], 32'd2);
`ifdef MDU_DIV_EARLY_OUT_EN
            check("coll_div_cycle", gc[1] - c0, MUL_LAT + 1);
`else
            check("coll_div_cycle", gc[1] - c0, 2 + DIV_LAT);
`endif
        end

        // Flush a divide 10 cycles after issue.
        drive(3'd4, 32'd100, 32'd7, 4'd7, 1'b0);
        idle(9);
        check("fl_div_ready_before", 32'(ready), 32'd0);
        p0 = npulse;
        do_flush();
        check("fl_div_ready_after", 32'(ready),  32'd1);
        check("fl_div_enable",      32'(cdb_en), 32'd0);
        idle(50);
        check("fl_div_no_pulse", npulse - p0, 32'd0);

        // Flush with a multiply in flight.
        p0 = npulse;
        drive(3'd0, 32'd9, 32'd9, 4'd8, 1'b0);
        do_flush();
        idle(10);
        check("fl_mul_no_pulse", npulse - p0, 32'd0);

        // Flush in the same cycle as issue: the issue is dropped.
        p0 = npulse;
        drive(3'd0, 32'd4, 32'd4, 4'd9, 1'b1);
        drive(3'd4, 32'd4, 32'd2, 4'd10, 1'b1);
        check("fl_same_ready", 32'(ready), 32'd1);
        idle(40);
        check("fl_same_no_pulse", npulse - p0, 32'd0);

        // Reset mid-multiply clears outputs and kills the op.
        drive(3'd0, 32'd6, 32'd7, 4'd11, 1'b0);
        idle(4);
        check("pre_rst_value", cdb_val, 32'd42);
        p0 = npulse;
        drive(3'd0, 32'd3, 32'd3, 4'd12, 1'b0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        clear_pending();
        check("mid_rst_enable",  32'(cdb_en),  32'd0);
        check("mid_rst_reorder", 32'(cdb_tag), 32'd0);
        check("mid_rst_value",   cdb_val,      32'd0);
        idle(10);
        check("mid_rst_no_pulse", npulse - p0, 32'd0);
        check("mid_rst_ready",    32'(ready),  32'd1);

        // Randomized traffic against the reference model.
        rt = 4'd0;
        for (int n = 0; n < 400; n++) begin
            if (ready && !exp_pend[rt] && $urandom_range(0, 3) != 0) begin
                drive(3'($urandom_range(0, 7)), pick(), pick(), rt, 1'b0);
                rt = rt + 4'd1;
            end else begin
                idle(1);
            end
        end
        for (int j = 0; j < 200 && pending_count() != 0; j++) idle(1);
        check("rand_drain", pending_count(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu_pipe.md
# mdu_pipe

Parametrised RV32M execution unit for the out-of-order core: a pipelined multiplier and an iterative radix-2 divider behind one reservation-station issue port. It drives one registered result broadcast that the ROB, the RS bypass network and the LSU bypass network all consume, alongside the single-cycle integer ALU. It is the multi-cycle successor of that ALU and adds tag-carrying pipelining, a divider FSM, result-slot arbitration and ROB flush.

## Interface
Parameters:
- DATA_W, 32, operand/result width
- ROB_W, 4, reorder tag width
- MUL_STAGES, 3, multiplier latency in cycles (>=1)

Ports:
- clk  in  1  clock; one clock domain
- rst  in  1  reset, synchronous, active-high
- rs2mdu_enable  in  1  issue strobe
- rs2mdu_op  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs2mdu_rs1  in  DATA_W  operand 1
- rs2mdu_rs2  in  DATA_W  operand 2
- rs2mdu_reorder  in  ROB_W  destination ROB tag
- mdu2rs_ready  out  1  unit can accept an issue this cycle
- rob2mdu_flush  in  1  mispredict rollback; kill all in-flight ops
- mdu2cdb_enable  out  1  result valid (one-cycle pulse per op)
- mdu2cdb_reorder  out  ROB_W  tag of result
- mdu2cdb_value  out  DATA_W  result value

## Operation
- Issue accepted at a rising edge when rs2mdu_enable && mdu2rs_ready && !rst && !rob2mdu_flush.
- mdu2rs_ready = divider in IDLE (combinational from state); it covers MUL ops too: while a divide is in flight, nothing is issued.
- Multiplier: MUL_STAGES-deep valid/tag/op pipeline; full 2*DATA_W product from operands extended per op (MULH s×s, MULHSU s×u, MULHU u×u); MUL returns low half, others high half.
- Divider FSM: IDLE -> CALC (DATA_W cycles, restoring, one quotient bit per cycle on magnitudes) -> FIX (apply sign: quotient negated if signs differ, remainder takes dividend sign) -> DONE -> IDLE.
- Special cases, exact RISC-V results: divide by zero -> quotient all ones, remainder = rs1; signed overflow (rs1 = 1<<(DATA_W-1), rs2 = all ones) -> quotient = rs1, remainder 0. Unsigned ops skip FIX sign work.
- Result slot arbitration: final multiplier stage has priority. DONE holds the divider result (tag and value) until a cycle where the final multiplier stage is empty, then drives it and returns to IDLE.
- Flush: at an edge with rob2mdu_flush high, all multiplier valids clear, divider -> IDLE, mdu2cdb_enable low next cycle; the same-cycle issue is dropped.
- rst: identical effect to flush plus all output registers to 0.

## Timing
- Reset values: mdu2cdb_enable 0, mdu2cdb_reorder 0, mdu2cdb_value 0; divider IDLE so mdu2rs_ready 1 once rst is low.
- All result outputs are registered. An op accepted at edge E0:
- MUL-class result valid in the cycle after edge E(MUL_STAGES); back-to-back issue gives back-to-back results, in order.
- DIV-class result valid in the cycle after edge E(DATA_W+2), plus one cycle per colliding multiplier result.
- mdu2rs_ready drops in the cycle after a divide is accepted and rises in the cycle after DONE drives its result.
- Flush and issue in the same cycle: flush wins.

## Configuration
- MDU_DIV_EARLY_OUT_EN defined: divide-by-zero and signed-overflow ops go IDLE -> DONE directly, and the result is valid in the cycle after E1 (subject to multiplier priority).
- Undefined: these ops run the full CALC/FIX path at DATA_W+2 latency and produce identical values.

## Test plan
- MUL rs1=7, rs2=0xFFFFFFFD, tag 5 -> tag 5, 0xFFFFFFEB, valid in the cycle after E3 (MUL_STAGES=3).
- MULH 0x80000000×0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF; MULHU 0xFFFFFFFF×2 -> 1; issued on consecutive cycles -> three consecutive pulses, tags in order.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD after 34 cycles, ready low throughout; REM of the same operands -> 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC.
- DIV x/0 -> 0xFFFFFFFF; REM x/0 -> x; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0. Latency 1 with MDU_DIV_EARLY_OUT_EN, 34 without.
- With MDU_DIV_EARLY_OUT_EN: MUL (tag 1) at E0, DIV-by-zero (tag 2) at E2 -> tag 1 in the cycle after E3, tag 2 in the cycle after E4.
- DIV issued, then flush 10 cycles later -> no result pulse, ready high in the next cycle; MUL in flight at flush -> no pulse; assert rst mid-multiply -> outputs 0, no pulse.
